// File: rtl/nmcu_mem_arbiter.sv
// nmcu_mem_arbiter: round-robin NUM_CH-to-1 memory request arbiter with write-burst lock and read-response routing (optional NMCU_ARB_STATS_EN grant counters)
module nmcu_mem_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 8,
  parameter int MAX_OUTST = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_req_valid,
  output logic [NUM_CH-1:0]        ch_req_ready,
  input  logic [NUM_CH-1:0]        ch_req_we,
  input  logic [NUM_CH*ADDR_W-1:0] ch_req_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_req_wdata,
  input  logic [NUM_CH*LEN_W-1:0]  ch_req_len,
  output logic [NUM_CH-1:0]        ch_resp_valid,
  output logic [DATA_W-1:0]        ch_resp_rdata,
  output logic                     ch_resp_last,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic                     mem_req_we,
  output logic [ADDR_W-1:0]        mem_req_addr,
  output logic [DATA_W-1:0]        mem_req_wdata,
  output logic [LEN_W-1:0]         mem_req_len,
  input  logic                     mem_resp_valid,
  input  logic [DATA_W-1:0]        mem_resp_rdata,
  output logic                     err_unexp_resp,
  output logic [NUM_CH*32-1:0]     grant_cnt
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int PW   = $clog2(MAX_OUTST) + 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nxt;
  logic [CH_W-1:0]   owner, rr_ptr, sel, idx, nxt_owner;
  logic [LEN_W-1:0]  beat_cnt, burst_len, rsp_cnt, len_eff, cur_len;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW-2:0]     wr_idx, rd_idx;
  logic [CH_W-1:0]   tag_ch  [MAX_OUTST];
  logic [LEN_W-1:0]  tag_len [MAX_OUTST];
  logic [ADDR_W-1:0] addr_a  [NUM_CH];
  logic [DATA_W-1:0] wdata_a [NUM_CH];
  logic [LEN_W-1:0]  len_a   [NUM_CH];
  logic busy, full, empty, blk, acc, done, w_last, push, pop, resp_hit;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign addr_a[i]  = ch_req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_a[i] = ch_req_wdata[i*DATA_W +: DATA_W];
    assign len_a[i]   = ch_req_len[i*LEN_W +: LEN_W];
  end
  assign busy          = state == BUSY;
  assign wr_idx        = wr_ptr[PW-2:0];
  assign rd_idx        = rd_ptr[PW-2:0];
  assign empty         = wr_ptr == rd_ptr;
  assign full          = (wr_ptr - rd_ptr) == PW'(MAX_OUTST);
  assign blk           = ~ch_req_we[owner] & full;
  assign mem_req_valid = busy & ch_req_valid[owner] & ~blk;
  assign mem_req_we    = busy & ch_req_we[owner];
  assign mem_req_addr  = busy ? addr_a[owner] : '0;
  assign mem_req_wdata = busy ? wdata_a[owner] : '0;
  assign mem_req_len   = busy ? len_a[owner] : '0;
  assign ch_req_ready  = busy ? ({{(NUM_CH-1){1'b0}}, mem_req_ready & ~blk} << owner) : '0;
  assign acc           = mem_req_valid & mem_req_ready;
  assign len_eff       = (len_a[owner] == '0) ? LEN_W'(1) : len_a[owner];
  assign cur_len       = (beat_cnt == '0) ? len_eff : burst_len;
  assign w_last        = beat_cnt == cur_len - LEN_W'(1);
  assign done          = acc & (~mem_req_we | w_last);
  assign push          = acc & ~mem_req_we;
  assign nxt_owner     = (owner == CH_W'(NUM_CH - 1)) ? '0 : owner + 1'b1;
  assign resp_hit      = mem_resp_valid & ~empty;
  assign ch_resp_last  = resp_hit & (rsp_cnt == tag_len[rd_idx]);
  assign pop           = ch_resp_last;
  assign ch_resp_valid = resp_hit ? ({{(NUM_CH-1){1'b0}}, 1'b1} << tag_ch[rd_idx]) : '0;
  assign ch_resp_rdata = resp_hit ? mem_resp_rdata : '0;
  // first valid channel at or after rr_ptr, wrapping; scanned backwards so the nearest wins
  always_comb begin
    sel = rr_ptr;
    idx = rr_ptr;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      if (ch_req_valid[idx]) sel = idx;
    end
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // grant on any request; release after a read or the final write beat
  always_comb begin
    state_nxt = state;
    state_nxt = busy ? (done ? IDLE : BUSY) : (|ch_req_valid ? BUSY : IDLE);
  end
  // owner capture, write-burst beat counting and round-robin pointer advance
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      owner     <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
      burst_len <= '0;
    end else begin
      if (!busy && |ch_req_valid) owner <= sel;
      if (acc && beat_cnt == '0) burst_len <= len_eff;
      if (done) rr_ptr <= nxt_owner;
      beat_cnt <= done ? '0 : (acc ? beat_cnt + 1'b1 : beat_cnt);
    end
  // tag FIFO pointers, response beat counter and sticky unexpected-response flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      rsp_cnt        <= '0;
      err_unexp_resp <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (resp_hit) rsp_cnt <= ch_resp_last ? '0 : rsp_cnt + 1'b1;
      if (mem_resp_valid && empty) err_unexp_resp <= 1'b1;
    end
  // tag storage: originating channel and burst length minus one
  always_ff @(posedge clk)
    if (push) begin
      tag_ch[wr_idx]  <= owner;
      tag_len[wr_idx] <= len_eff - LEN_W'(1);
    end
`ifdef NMCU_ARB_STATS_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_stats
    logic [31:0] cnt;
    // one count per accepted request beat of this channel, wrapping
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (acc && owner == CH_W'(i)) cnt <= cnt + 1'b1;
    assign grant_cnt[i*32 +: 32] = cnt;
  end
`else
  assign grant_cnt = '0;
`endif
endmodule

// File: tb/tb_nmcu_mem_arbiter.sv
// tb_nmcu_mem_arbiter: scoreboard bench with a round-robin reference model and a reactive memory model
module tb_nmcu_mem_arbiter;
  localparam int NCH = 4, AW = 32, DW = 32, LW = 8, MO = 4;
  logic clk = 0, rst_n = 0;
  logic [NCH-1:0] ch_req_valid = '0, ch_req_ready, ch_req_we = '0, ch_resp_valid;
  logic [NCH*AW-1:0] ch_req_addr = '0;
  logic [NCH*DW-1:0] ch_req_wdata = '0;
  logic [NCH*LW-1:0] ch_req_len = '0;
  logic [DW-1:0] ch_resp_rdata, mem_req_wdata, mem_resp_rdata = '0;
  logic ch_resp_last, mem_req_valid, mem_req_ready = 0, mem_req_we, mem_resp_valid = 0, err_unexp_resp;
  logic [AW-1:0] mem_req_addr;
  logic [LW-1:0] mem_req_len;
  logic [NCH*32-1:0] grant_cnt;

  nmcu_mem_arbiter #(.NUM_CH(NCH), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .MAX_OUTST(MO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_req_valid(ch_req_valid), .ch_req_ready(ch_req_ready), .ch_req_we(ch_req_we),
    .ch_req_addr(ch_req_addr), .ch_req_wdata(ch_req_wdata), .ch_req_len(ch_req_len),
    .ch_resp_valid(ch_resp_valid), .ch_resp_rdata(ch_resp_rdata), .ch_resp_last(ch_resp_last),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_len(mem_req_len),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
    .err_unexp_resp(err_unexp_resp), .grant_cnt(grant_cnt));

  always #5 clk = ~clk;

  typedef struct {bit we; logic [AW-1:0] addr; logic [DW-1:0] wdata; logic [LW-1:0] len; bit first;} beat_t;
  typedef struct {int ch; beat_t b;} exp_t;
  typedef struct {int ch; bit last;} rsp_t;

  beat_t cq [NCH][$];
  exp_t exp_q[$];
  rsp_t exp_rsp[$];
  int checks = 0, errors = 0, mptr = 0, cyc = 0, hs_cnt = 0, pend = 0, phase = 0;
  int stall_pct = 0, rdy_pct = 100, rsp_pct = 100, mem_len = 0, last_acc = 0, last_phase = -1;
  int mgrant[NCH];
  bit inj = 0, fair = 0, mem_acc = 0;
  bit acc_c[NCH];
  logic [DW-1:0] rd_drv = '0;

  function automatic int leff(logic [LW-1:0] l);
    return (l == 0) ? 1 : int'(l);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic load_txn(int c, bit we, int len);
    beat_t b;
    int n = we ? leff(LW'(len)) : 1;
    for (int k = 0; k < n; k++) begin
      b.we = we; b.addr = $urandom; b.wdata = $urandom; b.first = (k == 0);
      b.len = (k == 0) ? LW'(len) : LW'($urandom);
      cq[c].push_back(b);
    end
  endtask

  // reference: serve nonempty channels round-robin from the last winner + 1; writes take len beats, reads one
  task automatic build_model();
    beat_t t [NCH][$];
    exp_t e;
    rsp_t r;
    int c, n;
    bit any;
    for (int i = 0; i < NCH; i++) t[i] = cq[i];
    forever begin
      any = 0;
      for (int i = 0; i < NCH; i++) if (t[i].size() > 0) any = 1;
      if (!any) break;
      c = 0;
      for (int i = NCH - 1; i >= 0; i--) if (t[(mptr + i) % NCH].size() > 0) c = (mptr + i) % NCH;
      e.ch = c; e.b = t[c].pop_front();
      n = e.b.we ? leff(e.b.len) : 1;
      exp_q.push_back(e);
      for (int k = 1; k < n; k++) begin e.b = t[c].pop_front(); exp_q.push_back(e); end
      mgrant[c] += n;
      if (exp_q[$].b.we == 0) begin
        for (int k = 0; k < leff(exp_q[$].b.len); k++) begin
          r.ch = c; r.last = (k == leff(exp_q[$].b.len) - 1);
          exp_rsp.push_back(r);
        end
      end
      mptr = (c + 1) % NCH;
    end
  endtask

  task automatic drain(int budget);
    int n = 0;
    int left = 1;
    while (left != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
      left = exp_q.size() + exp_rsp.size() + pend;
      for (int i = 0; i < NCH; i++) left += cq[i].size();
    end
    chk("drain_left", 64'(left), 0);
  endtask

  task automatic inject_check();
    @(posedge clk); inj = 1;
    @(negedge clk); #1 inj = 0;
    @(posedge clk); #2;
    chk("err_unexp_set", err_unexp_resp, 1);
  endtask

  initial begin
    int h0, ge, w;
    for (int i = 0; i < NCH; i++) begin mgrant[i] = 0; acc_c[i] = 0; end
    fork
      begin : monitor
        exp_t e;
        rsp_t r;
        forever begin
          @(negedge clk);
          mem_acc = 0;
          for (int i = 0; i < NCH; i++) acc_c[i] = 0;
          if (rst_n) begin
            if (mem_req_valid && mem_req_ready) begin
              hs_cnt++;
              mem_acc = 1;
              mem_len = mem_req_we ? 0 : leff(mem_req_len);
              for (int i = 0; i < NCH; i++) acc_c[i] = ch_req_ready[i] & ch_req_valid[i];
              if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL req_unexpected actual=ch_ready %0h required=no request", ch_req_ready);
              end else begin
                e = exp_q.pop_front();
                chk("req_ready", 64'(ch_req_ready), 64'(1) << e.ch);
                chk("req_we", 64'(mem_req_we), 64'(e.b.we));
                chk("req_addr", 64'(mem_req_addr), 64'(e.b.addr));
                chk("req_wdata", 64'(mem_req_wdata), 64'(e.b.wdata));
                chk("req_len", 64'(mem_req_len), 64'(e.b.len));
              end
              if (fair) begin
                if (last_phase == phase) chk("rr_spacing", 64'(cyc - last_acc), 2);
                last_acc = cyc; last_phase = phase;
              end
            end
            if (mem_resp_valid) begin
              if (inj) chk("unexp_routed", 64'(ch_resp_valid), 0);
              else if (exp_rsp.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp_unexpected actual=%0h required=no response", ch_resp_valid);
              end else begin
                r = exp_rsp.pop_front();
                chk("resp_valid", 64'(ch_resp_valid), 64'(1) << r.ch);
                chk("resp_last", 64'(ch_resp_last), 64'(r.last));
                chk("resp_rdata", 64'(ch_resp_rdata), 64'(rd_drv));
              end
            end
          end
        end
      end
      begin : driver
        forever begin
          @(posedge clk); #1;
          cyc++;
          if (rst_n) begin
            for (int i = 0; i < NCH; i++) if (acc_c[i] && cq[i].size() > 0) void'(cq[i].pop_front());
            if (mem_acc) pend += mem_len;
          end
          for (int i = 0; i < NCH; i++) begin
            ch_req_valid[i] = 0;
            if (cq[i].size() > 0) begin
              ch_req_valid[i] = !(cq[i][0].we && !cq[i][0].first && $urandom_range(99) < stall_pct);
              ch_req_we[i] = cq[i][0].we;
              ch_req_addr[i*AW +: AW] = cq[i][0].addr;
              ch_req_wdata[i*DW +: DW] = cq[i][0].wdata;
              ch_req_len[i*LW +: LW] = cq[i][0].len;
            end
          end
          mem_req_ready = $urandom_range(99) < rdy_pct;
          mem_resp_valid = 0;
          if (inj) begin mem_resp_valid = 1; rd_drv = $urandom; end
          else if (pend > 0 && $urandom_range(99) < rsp_pct) begin mem_resp_valid = 1; rd_drv = $urandom; pend--; end
          mem_resp_rdata = rd_drv;
        end
      end
    join_none
    #3;
    chk("rst_mem_valid", 64'(mem_req_valid), 0);
    chk("rst_ch_ready", 64'(ch_req_ready), 0);
    chk("rst_resp_valid", 64'(ch_resp_valid), 0);
    chk("rst_err", 64'(err_unexp_resp), 0);
    chk("rst_grant_cnt", 64'(grant_cnt[63:0] | grant_cnt[127:64]), 0);
    @(negedge clk); @(negedge clk); rst_n = 1;
    inject_check();
    // round-robin fairness with len=1 reads and a memory that never stalls
    phase++; fair = 1;
    for (int c = 0; c < NCH; c++) for (int k = 0; k < 3; k++) load_txn(c, 0, 1);
    build_model(); drain(200); fair = 0;
    // write lock under owner stalls, another channel waiting
    phase++; stall_pct = 60;
    load_txn(1, 1, 4); load_txn(2, 0, 1);
    build_model(); drain(200); stall_pct = 0;
    // response routing across two bursts
    load_txn(3, 0, 3); load_txn(0, 0, 2);
    build_model(); drain(200);
    // tag FIFO full: five reads with memory silent
    rsp_pct = 0; h0 = hs_cnt;
    for (int c = 0; c < NCH; c++) load_txn(c, 0, 1 + $urandom_range(2));
    load_txn($urandom_range(NCH - 1), 0, 2);
    build_model();
    repeat (30) @(negedge clk);
    #1;
    chk("full_accepts", 64'(hs_cnt - h0), 4);
    chk("full_mem_valid", 64'(mem_req_valid), 0);
    chk("full_ch_ready", 64'(ch_req_ready), 0);
    rsp_pct = 100; drain(300);
    // randomized traffic
    stall_pct = 30; rdy_pct = 75; rsp_pct = 70;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < NCH; c++) begin
        w = $urandom_range(3);
        for (int k = 0; k < w; k++) load_txn(c, $urandom_range(1), $urandom_range(5));
      end
      build_model(); drain(2000);
    end
    for (int c = 0; c < NCH; c++) begin
`ifdef NMCU_ARB_STATS_EN
      ge = mgrant[c];
`else
      ge = 0;
`endif
      chk("grant_cnt", 64'(grant_cnt[c*32 +: 32]), 64'(ge));
    end
    chk("err_sticky", 64'(err_unexp_resp), 1);
    // asynchronous reset in the middle of a write burst
    stall_pct = 0; rdy_pct = 100; rsp_pct = 100; h0 = hs_cnt;
    load_txn(1, 1, 4); build_model();
    w = 0;
    while (hs_cnt < h0 + 2 && w < 50) begin @(negedge clk); #1; w++; end
    chk("midburst_reached", 64'(hs_cnt - h0 >= 2), 1);
    #1 rst_n = 0;
    #1;
    chk("arst_mem_valid", 64'(mem_req_valid), 0);
    chk("arst_mem_we", 64'(mem_req_we), 0);
    chk("arst_mem_addr", 64'(mem_req_addr), 0);
    chk("arst_ch_ready", 64'(ch_req_ready), 0);
    chk("arst_err", 64'(err_unexp_resp), 0);
    chk("arst_grant_cnt", 64'(grant_cnt[63:0] | grant_cnt[127:64]), 0);
    for (int c = 0; c < NCH; c++) begin cq[c].delete(); mgrant[c] = 0; end
    exp_q.delete(); exp_rsp.delete(); pend = 0; mptr = 0;
    @(negedge clk); @(negedge clk); rst_n = 1;
    load_txn(2, 0, 2); load_txn(3, 1, 2);
    build_model(); drain(200);
    inject_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
